// File: rtl/sti_dac_pkg.sv
// Shared types and constants for the serial-to-pixel-RAM packer.
// The index-to-location mapping lives here so every user applies the same checkerboard layout.
package sti_dac_pkg;

    localparam int BYTE_W   = 8;
    localparam int IMG_LOG2 = 8;
    localparam int BANK_AW  = IMG_LOG2 - 2;
    localparam int IMG_SIZE = 1 << IMG_LOG2;
    localparam int IDX_W    = IMG_LOG2 + 1;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        FILL    = 2'd1,
        DONE    = 2'd2
    } state_e;

    typedef struct packed {
        logic [1:0]         bank;
        logic [BANK_AW-1:0] addr;
    } mem_loc_t;

    // Row parity and column parity select the bank; the remaining row/column bits form the address.
    function automatic mem_loc_t map_index(input logic [IMG_LOG2-1:0] n);
        mem_loc_t loc;
        loc.bank = {n[4], n[0]};
        loc.addr = {n[7:5], n[3:1]};
        return loc;
    endfunction

endpackage

// File: rtl/sti_dac_addr_map.sv
// Pure combinational mapping of a linear pixel index onto the 4-bank checkerboard memory.
module sti_dac_addr_map
    import sti_dac_pkg::*;
(
    input  logic [IMG_LOG2-1:0] n,
    output logic [1:0]          bank,
    output logic [BANK_AW-1:0]  addr
);

    mem_loc_t loc;

    always_comb begin
        loc = map_index(n);
    end

    assign bank = loc.bank;
    assign addr = loc.addr;

endmodule

// File: rtl/sti_dac_packer.sv
// Packs the serial bit stream MSB-first into bytes, writes them into the checkerboard pixel RAMs,
// then zero-fills the rest of the image. Optional macro STI_DAC_WR_COUNT_EN adds the data_cnt output.
module sti_dac_packer
    import sti_dac_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               so_valid,
    input  logic               so_data,
    input  logic               pi_end,
    output logic               mem_wr,
    output logic [1:0]         mem_bank,
    output logic [BANK_AW-1:0] mem_addr,
    output logic [BYTE_W-1:0]  mem_data,
    output logic               done
`ifdef STI_DAC_WR_COUNT_EN
    ,
    output logic [IDX_W-1:0]   data_cnt
`endif
);

    localparam idx_t LAST_N = idx_t'(IMG_SIZE - 1);
    localparam idx_t N_ONE  = idx_t'(1);

    state_e             state_q, state_d;
    logic [BYTE_W-1:0]  sr_q, sr_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    idx_t               n_q, n_d;
    logic               end_seen_q, end_seen_d;
    logic               mem_wr_q, mem_wr_d;
    logic [1:0]         mem_bank_q, mem_bank_d;
    logic [BANK_AW-1:0] mem_addr_q, mem_addr_d;
    logic [BYTE_W-1:0]  mem_data_q, mem_data_d;
    logic               done_q, done_d;

    logic [1:0]         map_bank;
    logic [BANK_AW-1:0] map_addr;
    logic               accept;
    logic [BYTE_W-1:0]  pad_data;

    sti_dac_addr_map u_addr_map (
        .n    (n_q[IMG_LOG2-1:0]),
        .bank (map_bank),
        .addr (map_addr)
    );

    // A bit coinciding with pi_end is already past the end of the stream.
    assign accept   = so_valid && !end_seen_q && !pi_end;
    assign pad_data = sr_q << (4'd8 - {1'b0, bit_cnt_q});

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        n_d        = n_q;
        end_seen_d = end_seen_q;
        mem_wr_d   = 1'b0;
        mem_bank_d = mem_bank_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        done_d     = done_q || (state_q == DONE);

        case (state_q)
            COLLECT: begin
                if (pi_end) begin
                    end_seen_d = 1'b1;
                end
                if (end_seen_q) begin
                    // Flush the partial byte, or start the zero fill right away when none is pending.
                    mem_wr_d   = 1'b1;
                    mem_bank_d = map_bank;
                    mem_addr_d = map_addr;
                    mem_data_d = (bit_cnt_q != 3'd0) ? pad_data : '0;
                    n_d        = n_q + N_ONE;
                    bit_cnt_d  = 3'd0;
                    state_d    = (n_q == LAST_N) ? DONE : FILL;
                end else if (accept) begin
                    sr_d      = {sr_q[BYTE_W-2:0], so_data};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        mem_wr_d   = 1'b1;
                        mem_bank_d = map_bank;
                        mem_addr_d = map_addr;
                        mem_data_d = {sr_q[BYTE_W-2:0], so_data};
                        n_d        = n_q + N_ONE;
                        if (n_q == LAST_N) begin
                            state_d = DONE;
                        end
                    end
                end
            end

            FILL: begin
                mem_wr_d   = 1'b1;
                mem_bank_d = map_bank;
                mem_addr_d = map_addr;
                mem_data_d = '0;
                n_d        = n_q + N_ONE;
                if (n_q == LAST_N) begin
                    state_d = DONE;
                end
            end

            DONE: begin
            end

            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= COLLECT;
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            n_q        <= '0;
            end_seen_q <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_bank_q <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            n_q        <= n_d;
            end_seen_q <= end_seen_d;
            mem_wr_q   <= mem_wr_d;
            mem_bank_q <= mem_bank_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            done_q     <= done_d;
        end
    end

    assign mem_wr   = mem_wr_q;
    assign mem_bank = mem_bank_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign done     = done_q;

`ifdef STI_DAC_WR_COUNT_EN
    localparam idx_t CNT_MAX = idx_t'(IMG_SIZE);

    idx_t data_cnt_q, data_cnt_d;
    logic collect_wr;

    // Zero-fill writes issued from COLLECT (no partial byte pending) are not data writes.
    assign collect_wr = mem_wr_d && (state_q == COLLECT) &&
                        !(end_seen_q && (bit_cnt_q == 3'd0));

    always_comb begin
        data_cnt_d = data_cnt_q;
        if (collect_wr && (data_cnt_q != CNT_MAX)) begin
            data_cnt_d = data_cnt_q + N_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_cnt_q <= '0;
        end else begin
            data_cnt_q <= data_cnt_d;
        end
    end

    assign data_cnt = data_cnt_q;
`endif

endmodule

// File: tb/tb_sti_dac_packer.sv
// Directed bench for sti_dac_packer: streams bytes, partial bytes, empty and overflowing images,
// and mid-stream resets, checking every memory write against hand-derived values.
module tb_sti_dac_packer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       so_valid = 1'b0;
    logic       so_data = 1'b0;
    logic       pi_end = 1'b0;
    logic       mem_wr;
    logic [1:0] mem_bank;
    logic [5:0] mem_addr;
    logic [7:0] mem_data;
    logic       done;
`ifdef STI_DAC_WR_COUNT_EN
    logic [8:0] data_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [15:0] wq[$];

    sti_dac_packer dut (
        .clk      (clk),
        .rst      (rst),
        .so_valid (so_valid),
        .so_data  (so_data),
        .pi_end   (pi_end),
        .mem_wr   (mem_wr),
        .mem_bank (mem_bank),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .done     (done)
`ifdef STI_DAC_WR_COUNT_EN
        ,
        .data_cnt (data_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && mem_wr) begin
            wq.push_back({mem_bank, mem_addr, mem_data});
            $display("write #%0d bank=%0d addr=%0d data=0x%02h", wq.size() - 1, mem_bank, mem_addr, mem_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // {bank, addr}: bank = {row parity, column parity}, addr = {row[3:1], col[3:1]}
    function automatic logic [7:0] exp_loc(input int i);
        logic [7:0] v;
        v = i[7:0];
        return {v[4], v[0], v[7:5], v[3:1]};
    endfunction

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        so_valid = 1'b0;
        so_data  = 1'b0;
        pi_end   = 1'b0;
        rst      = 1'b1;
        #1;
        step(2);
        rst = 1'b0;
        wq.delete();
    endtask

    task automatic send_bit(input logic b);
        so_valid = 1'b1;
        so_data  = b;
        @(posedge clk);
        #1;
        so_valid = 1'b0;
        so_data  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (done !== 1'b1 && k < budget) begin
            step(1);
            k++;
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    // Entries from index 'first' up to 255 must be zero data at the mapped location.
    task automatic check_fill(input string tag, input int first);
        int bad;
        bad = 0;
        for (int i = first; i < 256; i++) begin
            if (i >= wq.size()) bad++;
            else if (wq[i] !== {exp_loc(i), 8'h00}) bad++;
        end
        check(tag, bad, 0);
    endtask

    initial begin
        int c0;
        int elapsed;
        int bad;
        logic [7:0] pat;

        // Reset values, observed while rst is still held.
        #1;
        check("rst_mem_wr",   {31'd0, mem_wr}, 32'd0);
        check("rst_mem_bank", {30'd0, mem_bank}, 32'd0);
        check("rst_mem_addr", {26'd0, mem_addr}, 32'd0);
        check("rst_mem_data", {24'd0, mem_data}, 32'd0);
        check("rst_done",     {31'd0, done}, 32'd0);

        // Two back-to-back bytes, then end of stream.
        apply_reset();
        send_byte(8'h5A);
        send_byte(8'hC3);
        pi_end = 1'b1;
        step(1);
        pi_end = 1'b0;
        wait_done("t1_done", 400);
        check("t1_count", wq.size(), 256);
        check("t1_w0", {16'd0, wq[0]}, {16'd0, 2'd0, 6'd0, 8'h5A});
        check("t1_w1", {16'd0, wq[1]}, {16'd0, 2'd1, 6'd0, 8'hC3});
        check_fill("t1_fill", 2);
        check("t1_last", {16'd0, wq[255]}, {16'd0, 2'd3, 6'd63, 8'h00});

        // 0x81 with an idle cycle before every bit.
        apply_reset();
        pat = 8'h81;
        for (int i = 7; i >= 1; i--) begin
            step(1);
            send_bit(pat[i]);
        end
        check("t2_no_early_wr", {31'd0, mem_wr}, 32'd0);
        step(1);
        send_bit(pat[0]);
        check("t2_wr",   {31'd0, mem_wr}, 32'd1);
        check("t2_data", {24'd0, mem_data}, 32'h81);
        check("t2_loc",  {24'd0, mem_bank, mem_addr}, 32'd0);
        step(1);
        check("t2_wr_once", {31'd0, mem_wr}, 32'd0);
        step(2);
        check("t2_data_hold", {24'd0, mem_data}, 32'h81);
        check("t2_count", wq.size(), 1);

        // Partial byte 101, with the transmitter holding valid high from pi_end onward.
        apply_reset();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        so_valid = 1'b1;
        so_data  = 1'b1;
        pi_end   = 1'b1;
        step(1);
        pi_end = 1'b0;
        wait_done("t3_done", 400);
        so_valid = 1'b0;
        so_data  = 1'b0;
        check("t3_count", wq.size(), 256);
        check("t3_w0", {16'd0, wq[0]}, {16'd0, 2'd0, 6'd0, 8'hA0});
        check_fill("t3_fill", 1);

        // End of stream with no data at all.
        apply_reset();
        c0 = cyc;
        pi_end = 1'b1;
        step(1);
        pi_end = 1'b0;
        wait_done("t4_done", 400);
        elapsed = cyc - c0;
        check("t4_latency_ok", {31'd0, (elapsed >= 256 && elapsed <= 259)}, 32'd1);
        check("t4_count_at_done", wq.size(), 256);
        check_fill("t4_fill", 0);

        // 256 full bytes, then extra bits and a late pi_end that must be ignored.
        apply_reset();
        for (int i = 0; i < 256; i++) send_byte(8'(i) ^ 8'h3C);
        so_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            so_data = 1'($urandom_range(0, 1));
            step(1);
        end
        so_valid = 1'b0;
        pi_end = 1'b1;
        step(1);
        pi_end = 1'b0;
        step(4);
        check("t5_count", wq.size(), 256);
        check("t5_done", {31'd0, done}, 32'd1);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (i >= wq.size()) bad++;
            else if (wq[i] !== {exp_loc(i), 8'(i) ^ 8'h3C}) bad++;
        end
        check("t5_data", bad, 0);
`ifdef STI_DAC_WR_COUNT_EN
        check("t5_data_cnt", {23'd0, data_cnt}, 32'd256);
`endif

        // Reset lands on an in-flight write.
        apply_reset();
        send_byte(8'h3C);
        check("t6_inflight", {31'd0, mem_wr}, 32'd1);
        rst = 1'b1;
        #1;
        check("t6_wr_dropped", {31'd0, mem_wr}, 32'd0);
        check("t6_data_clr",   {24'd0, mem_data}, 32'd0);

        // Reset after four bits, then a clean byte.
        apply_reset();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        apply_reset();
        send_byte(8'hFF);
        step(2);
        check("t6_count", wq.size(), 1);
        check("t6_w0", {16'd0, wq[0]}, {16'd0, 2'd0, 6'd0, 8'hFF});
        check("t6_not_done", {31'd0, done}, 32'd0);
`ifdef STI_DAC_WR_COUNT_EN
        check("t6_data_cnt", {23'd0, data_cnt}, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sti_dac_packer.md
Name: sti_dac_packer

Overview:
- Downstream consumer of the serial transmitter stage. Samples the serial bit stream (so_valid/so_data), packs it MSB-first into bytes and writes each byte into a 4-bank checkerboard pixel memory for a 16x16 image.
- After end-of-stream, zero-fills every remaining pixel location, then raises done.
- Sits between the serial transmitter and the four 64x8 pixel RAMs.

Parameters:
- BYTE_W, 8, bits per pixel byte; fixed at 8 in this revision.
- IMG_LOG2, 8, log2 of total pixel count (256 = 16x16); bank address width = IMG_LOG2-2.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- so_valid  in  1  serial bit valid, from transmitter
- so_data  in  1  serial bit, MSB of each byte first
- pi_end  in  1  end-of-stream indication; level or pulse; latched internally
- mem_wr  out  1  one-cycle write strobe
- mem_bank  out  2  target bank {row parity, column parity}
- mem_addr  out  6  address within bank
- mem_data  out  8  write data
- done  out  1  high once all 256 locations are written; sticky until reset

Behaviour:
- Reset (async): state=COLLECT, shift reg=0, bit_cnt=0, byte index n=0, end_seen=0, mem_wr=0, mem_bank=0, mem_addr=0, mem_data=0, done=0.
- Address map for byte index n[7:0]:
  - row=n[7:4], col=n[3:0]
  - mem_bank={n[4], n[0]}
  - mem_addr={n[7:5], n[3:1]}
- All mem_* outputs are registered. mem_bank, mem_addr and mem_data are valid in the cycle mem_wr=1 and hold their last value otherwise.
- State COLLECT:
  - A bit is accepted when so_valid=1 and end_seen=0. Shift left: sr <= {sr[6:0], so_data}; bit_cnt++.
  - When the 8th bit is accepted (bit_cnt==7) in cycle t:
    - in cycle t+1: mem_wr=1, mem_data={sr[6:0], so_data}, address from n;
    - then n++ and bit_cnt wraps to 0.
  - Throughput is one byte per 8 valid cycles. Back-to-back bytes with no gap are supported.
  - pi_end=1 sets end_seen. Bits arriving in the same cycle as pi_end, or later, are ignored; the transmitter holds so_valid high in its finish state, so this rule is mandatory.
  - Partial byte at end (bit_cnt!=0): the cycle after end_seen, write the partial byte left-aligned and zero-padded (e.g. 3 bits 101 -> 0xA0), then n++.
  - Next state: FILL, or DONE if n has reached 256.
- State FILL: one write per cycle with mem_data=0x00 at n, n++. After the write of n=255 -> DONE.
- State DONE: done=1, mem_wr=0. All inputs are ignored until reset.
- Overflow: if 256 bytes are written in COLLECT before pi_end, go to DONE immediately. Further bits are dropped.
- Reset mid-stream: all state is cleared at once. Any in-flight write is lost (mem_wr drops asynchronously).
- pi_end while n=0 and bit_cnt=0: fill all 256 locations with 0x00 (256 write cycles).

Optional Feature:
- Macro STI_DAC_WR_COUNT_EN.
- Defined: adds output data_cnt [8:0]. Reset 0; increments on every COLLECT-state write, including the padded partial byte; never counts FILL writes; saturates at 256.
- Undefined: no port and no counter logic; behaviour is otherwise identical.

Decomposition:
- Shared package sti_dac_pkg:
  - state enum {COLLECT, FILL, DONE}
  - BYTE_W, IMG_LOG2 constants
  - function mapping n to {bank, addr}, for reuse by the bench scoreboard.
- One natural sub-module: sti_dac_addr_map, purely the n -> bank/addr mapping. The FSM, shift register and counters stay in the top module.

Test Plan:
- Bytes 0x5A, 0xC3 streamed back-to-back, then pi_end:
  - write n=0: bank0/addr0, data 0x5A;
  - write n=1: bank1/addr0, data 0xC3;
  - then 254 zero writes; done=1 after n=255 (bank3/addr63).
- so_valid toggling with gaps while sending 0x81: exactly one write of 0x81, one cycle after the 8th accepted bit.
- 3 bits 1,0,1 then pi_end: write 0xA0 at n=0, then fill n=1..255 with 0x00.
- pi_end right after reset with no bits: 256 zero writes; done at cycle 257 ±1; no data writes.
- 256 bytes streamed then extra bits with so_valid=1: exactly 256 writes; done=1; extra bits cause no mem_wr.
- rst asserted mid-byte after 4 bits, then stream 0xFF: first write is 0xFF at n=0. With STI_DAC_WR_COUNT_EN, data_cnt=1.
